load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_i  input  1  core access request, sampled only while busy_o=0.
REQ-005 SHALL have port we_i  input  1  1=store, 0=load.
REQ-006 SHALL have port size_i  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 SHALL have port unsigned_i  input  1  1=zero-extend loads, 0=sign-extend.
REQ-008 SHALL have port addr_i  input  32  byte address.
REQ-009 SHALL have port wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata_o  output  32  extended load result, valid while done_o=1.
REQ-013 SHALL have port err_o  output  1  misaligned access flag, valid while done_o=1.
REQ-014 SHALL have port Mem_Read_o  output  1  memory read enable.
REQ-015 SHALL have port Mem_Write_o  output  1  memory write enable, one cycle per store.
REQ-016 SHALL have port Address_o  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-017 SHALL have port Write_Data_o  output  32  full word written to memory.
REQ-018 SHALL have port Read_Data_i  input  32  memory read word, combinational from Address_o.

Function
REQ-019 SHALL use FSM states IDLE, READ, WRITE, DONE.
REQ-020 SHALL, in IDLE with req_i=1, latch addr_i, wdata_i, size_i, we_i and unsigned_i, then transition: load -> READ; word store -> WRITE; byte/half store -> READ.
REQ-021 SHALL, in READ, assert Mem_Read_o=1 and capture Read_Data_i into an internal word register; next state is DONE for loads and WRITE for stores.
REQ-022 SHALL, in WRITE, assert Mem_Write_o=1 with Write_Data_o = captured word with the addressed byte/half lane replaced by wdata_i (word store: wdata_i); next state DONE.
REQ-023 SHALL, in DONE, assert done_o=1 for exactly one cycle, then return to IDLE.
REQ-024 SHALL have latency, accept edge to done_o high: load 2 cycles, word store 2 cycles, byte/half store 3 cycles.
REQ-025 SHALL select load lanes as byte addr[1:0]*8 and half addr[1]*16, extending to 32 bits per unsigned_i.
REQ-026 SHALL keep Mem_Read_o and Mem_Write_o low in IDLE and DONE, and SHALL never assert both in the same cycle.
REQ-027 SHALL ignore req_i while busy_o=1, with no queueing; req_i in the DONE cycle is dropped.
REQ-028 SHALL hold rdata_o at its last value outside DONE, and SHALL drive rdata_o=0 for stores.
REQ-029 SHALL drive Address_o from the latched address throughout the access, stable from READ/WRITE entry through DONE.

Reset
REQ-030 SHALL, on reset=0 at a rising edge, go to IDLE with busy_o, done_o, err_o, Mem_Read_o and Mem_Write_o =0, and rdata_o, Address_o, Write_Data_o =0.
REQ-031 SHALL abort an in-flight access on reset: no Mem_Write_o pulse and no done_o after the reset edge.

Configuration
REQ-032 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, treat half with addr[0]=1 and word with addr[1:0]!=0 as misaligned: IDLE -> DONE directly, err_o=1, rdata_o=0, no memory strobes, latency 1.
REQ-033 SHALL, without LSU_MISALIGN_TRAP_EN, tie err_o to 0 and align silently: half ignores addr[0], word ignores addr[1:0].

Verification
REQ-034 SHALL be verified as follows: sw 0x11223344 @0x24 -> WRITE cycle Address_o=0x24, Write_Data_o=0x11223344, done_o 2 cycles after accept.
REQ-035 SHALL be verified as follows: after REQ-034, lb @0x25 signed -> rdata_o=0x00000033; lb @0x27 -> 0x00000011.
REQ-036 SHALL be verified as follows: word 0x80FF0000 @0x10; lh @0x12 -> rdata_o=0xFFFF80FF; lhu @0x12 -> 0x000080FF.
REQ-037 SHALL be verified as follows: word 0x11223344 @0x24; sb 0xAB @0x26 -> one READ then Mem_Write_o with Write_Data_o=0x11AB3344, done_o 3 cycles after accept.
REQ-038 SHALL be verified as follows: lw @0x22 -> with macro, done_o+err_o=1 next cycle with no strobes; without macro, reads word @0x20 with err_o=0.
REQ-039 SHALL be verified as follows: reset=0 during READ of sb -> Mem_Write_o never asserted, IDLE next cycle, busy_o=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide memory via an IDLE/READ/WRITE/DONE FSM.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  Mem_Read_o,
  output logic                  Mem_Write_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wr_q, wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] extended;
  logic [BYTE_W-1:0]     byte_sel;
  logic [HALF_W-1:0]     half_sel;
  logic                  misalign_c;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q, err_d;

  assign misalign_c = ((size_i == 2'b01) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));

  // Error flag is decided at accept and only observed during DONE.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && req_i) err_d = misalign_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign misalign_c = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Lane extraction / insertion on the memory word, always relative to the latched address.
  always_comb begin
    byte_sel = Read_Data_i[{addr_q[1:0], 3'b000} +: BYTE_W];
    half_sel = Read_Data_i[{addr_q[1], 4'b0000} +: HALF_W];
    merged   = Read_Data_i;
    extended = Read_Data_i;
    case (size_q)
      2'b00: begin
        merged[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
        extended = uns_q ? {{(DATA_WIDTH-BYTE_W){1'b0}}, byte_sel}
                         : {{(DATA_WIDTH-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      end
      2'b01: begin
        merged[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
        extended = uns_q ? {{(DATA_WIDTH-HALF_W){1'b0}}, half_sel}
                         : {{(DATA_WIDTH-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      end
      default: merged = wdata_q;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          size_d  = size_i;
          we_d    = we_i;
          uns_d   = unsigned_i;
          if (misalign_c) begin
            state_d = DONE;
            rdata_d = '0;
          end else if (we_i && size_i[1]) begin
            state_d = WRITE;
            wr_d    = wdata_i;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d = WRITE;
          wr_d    = merged;
        end else begin
          state_d = DONE;
          rdata_d = extended;
        end
      end
      WRITE: begin
        state_d = DONE;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wr_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign Mem_Read_o   = (state_q == READ);
  assign Mem_Write_o  = (state_q == WRITE);
  assign Address_o    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign Write_Data_o = wr_q;
  assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a small word-addressed memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when that macro is defined.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o, Mem_Read_o, Mem_Write_o;
  logic [31:0] rdata_o, Address_o, Write_Data_o, Read_Data_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [64] = '{default: '0};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .Address_o(Address_o),
    .Write_Data_o(Write_Data_o), .Read_Data_i(Read_Data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Read_Data_i = mem[Address_o[7:2]];
  always @(posedge clk) if (Mem_Write_o) mem[Address_o[7:2]] <= Write_Data_o;

  // Single comparison point: count the vector and report a miscompare.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access: push expectation, drive request, follow strobes until done, pop and compare.
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_er, input int exp_lat, input int exp_nwr,
                        input logic [31:0] exp_wd, input bit hold);
    exp_t e;
    int   lat, nwr, nrd;
    bit   both;
    e.rdata = exp_rd; e.err = exp_er; e.lat = exp_lat; e.nwr = exp_nwr;
    e.wdata = exp_wd; e.addr = {a[31:2], 2'b00};
    sb_q.push_back(e);
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(negedge clk);
    if (!hold) req_i = 1'b0;
    lat = 1; nwr = 0; nrd = 0; both = 0;
    while (done_o !== 1'b1 && lat < 8) begin
      if (Mem_Read_o && Mem_Write_o) both = 1;
      if (Mem_Read_o) nrd++;
      if (Mem_Write_o) begin
        nwr++;
        chk({tag, ".wdata"}, Write_Data_o, e.wdata);
      end
      if (Mem_Read_o || Mem_Write_o) chk({tag, ".addr"}, Address_o, e.addr);
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, ".done"}, 32'(done_o), 32'h1);
    chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
    chk({tag, ".rdata"}, rdata_o, e.rdata);
    chk({tag, ".err"}, 32'(err_o), 32'(e.err));
    chk({tag, ".nwr"}, 32'(nwr), 32'(e.nwr));
    chk({tag, ".nrd"}, 32'(nrd), 32'(e.lat - 1 - e.nwr));
    chk({tag, ".both"}, 32'(both), 32'h0);
    chk({tag, ".strb_done"}, 32'({Mem_Read_o, Mem_Write_o}), 32'h0);
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy_o), 32'h0);
    chk({tag, ".idle_done"}, 32'(done_o), 32'h0);
    req_i = 1'b0;
    if (hold) begin
      @(negedge clk);
      chk({tag, ".no_requeue"}, 32'(busy_o), 32'h0);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy_o), 32'h0);
    chk("rst.done", 32'(done_o), 32'h0);
    chk("rst.err", 32'(err_o), 32'h0);
    chk("rst.mr", 32'(Mem_Read_o), 32'h0);
    chk("rst.mw", 32'(Mem_Write_o), 32'h0);
    chk("rst.rdata", rdata_o, 32'h0);
    chk("rst.addr", Address_o, 32'h0);
    chk("rst.wdata", Write_Data_o, 32'h0);
    reset = 1'b1;

    access("sw24",    1, 2'b10, 0, 32'h24, 32'h11223344, 32'h0,        0, 2, 1, 32'h11223344, 0);
    access("lb25",    0, 2'b00, 0, 32'h25, 32'h0,        32'h00000033, 0, 2, 0, 32'h0,        0);
    access("lb27",    0, 2'b00, 0, 32'h27, 32'h0,        32'h00000011, 0, 2, 0, 32'h0,        0);
    access("sw10",    1, 2'b10, 0, 32'h10, 32'h80FF0000, 32'h0,        0, 2, 1, 32'h80FF0000, 0);
    access("lh12",    0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0,        0);
    access("lhu12",   0, 2'b01, 1, 32'h12, 32'h0,        32'h000080FF, 0, 2, 0, 32'h0,        0);
    access("sb26",    1, 2'b00, 0, 32'h26, 32'h000000AB, 32'h0,        0, 3, 1, 32'h11AB3344, 0);
    access("lw24s11", 0, 2'b11, 0, 32'h24, 32'h0,        32'h11AB3344, 0, 2, 0, 32'h0,        1);
    access("lb24",    0, 2'b00, 0, 32'h24, 32'h0,        32'h00000044, 0, 2, 0, 32'h0,        0);
    access("sw20",    1, 2'b11, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0, 2, 1, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    access("lw22",    0, 2'b10, 0, 32'h22, 32'h0,        32'h0,        1, 1, 0, 32'h0,        0);
`else
    access("lw22",    0, 2'b10, 0, 32'h22, 32'h0,        32'hCAFEF00D, 0, 2, 0, 32'h0,        0);
`endif
    access("sh12",    1, 2'b01, 0, 32'h12, 32'h5555BEEF, 32'h0,        0, 3, 1, 32'hBEEF0000, 0);
    access("lb13",    0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFBE, 0, 2, 0, 32'h0,        0);
    access("lbu13",   0, 2'b00, 1, 32'h13, 32'h0,        32'h000000BE, 0, 2, 0, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
    access("sh11",    1, 2'b01, 0, 32'h11, 32'h00001234, 32'h0,        1, 1, 0, 32'h0,        0);
    access("lw10",    0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEF0000, 0, 2, 0, 32'h0,        0);
`else
    access("sh11",    1, 2'b01, 0, 32'h11, 32'h00001234, 32'h0,        0, 3, 1, 32'hBEEF1234, 0);
    access("lw10",    0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEF1234, 0, 2, 0, 32'h0,        0);
`endif

    // Reset during the READ phase of a byte store aborts it.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 32'h24; wdata_i = 32'h55;
    @(negedge clk);
    req_i = 1'b0;
    chk("abort.in_read", 32'(Mem_Read_o), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort.busy", 32'(busy_o), 32'h0);
    chk("abort.mw", 32'(Mem_Write_o), 32'h0);
    chk("abort.done", 32'(done_o), 32'h0);
    chk("abort.rdata", rdata_o, 32'h0);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (Mem_Write_o || done_o) seen = 1;
    end
    chk("abort.no_strobe", 32'(seen), 32'h0);
    chk("abort.mem", mem[9], 32'h11AB3344);
    access("lw24post", 0, 2'b10, 0, 32'h24, 32'h0, 32'h11AB3344, 0, 2, 0, 32'h0, 0);

    chk("sb.empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
